// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// State encoding and default frame/baud parameters.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int UART_DIV_RATE = 260;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser plus history flop for the rx pin.
// Ports: clk, reset (async low), rx in; rx_s synced line, fall edge pulse.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rx_s = s2;
  assign fall = hist & ~s2;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with one-deep buffer and status flags.
// Ports: clk, reset, rx, rx_ack in; rx_data, rx_end, rx_full,
// rx_overrun, rx_frame_err, rx_busy out.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_RATE = UART_DIV_RATE,
  parameter int DATA_W   = UART_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_end,
  output logic              rx_full,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  output logic              rx_busy
);

  localparam int CW = $clog2(DIV_RATE);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(DIV_RATE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV_RATE - 1);
  localparam logic [BW-1:0] LAST_B  = BW'(DATA_W - 1);

  logic              rx_s;
  logic              fall;
  logic [1:0]        state;
  logic [CW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_end       <= 1'b0;
      rx_full      <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_end       <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_ack) begin
        rx_full    <= 1'b0;
        rx_overrun <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          if (fall)
            state <= ST_START;
        end
        ST_START: begin
          if (div_cnt == HALF_M1) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (div_cnt == FULL_M1) begin
            div_cnt <= '0;
            shreg   <= {rx_s, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_B)
              state <= ST_STOP;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (div_cnt == FULL_M1) begin
            div_cnt <= '0;
            state   <= ST_IDLE;
            if (rx_s) begin
              // Frame beats a simultaneous ack; newest byte wins.
              rx_data    <= shreg;
              rx_end     <= 1'b1;
              rx_full    <= 1'b1;
              rx_overrun <= rx_full & ~rx_ack;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized bench for uart_rx_core at DIV_RATE=16.
// Reference model tracks expected byte/full/overrun per frame.
module tb_uart_rx_core;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_end;
  logic       rx_full;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int end_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int end_cyc = 0;
  logic prev_busy = 1'b0;

  logic [7:0] m_data = 8'h00;
  logic       m_full = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx_core #(.DIV_RATE(DIV), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_end       (rx_end),
    .rx_full      (rx_full),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_end) begin
      end_cnt = end_cnt + 1;
      end_cyc = cyc;
    end
    if (rx_frame_err) err_cnt = err_cnt + 1;
    if (rx_busy) busy_cnt = busy_cnt + 1;
    if (rx_busy && !prev_busy) rise_cyc = cyc;
    prev_busy = rx_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(1);
    m_full = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop,
                             input logic ack);
    if (stop) begin
      m_ovr = m_full && !ack ? 1'b1 : (ack ? 1'b0 : m_ovr);
      m_full = 1'b1;
      m_data = d;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, "_full"}, 32'(rx_full), 32'(m_full));
    chk({tag, "_ovr"}, 32'(rx_overrun), 32'(m_ovr));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d,
                          input logic stop);
    int e0;
    int f0;
    e0 = end_cnt;
    f0 = err_cnt;
    send_frame(d, stop);
    model_frame(d, stop, 1'b0);
    chk({tag, "_ends"}, 32'(end_cnt - e0), 32'(stop ? 1 : 0));
    chk({tag, "_ferr"}, 32'(err_cnt - f0), 32'(stop ? 0 : 1));
    check_state(tag);
  endtask

  initial begin
    int e0;
    int f0;
    int b0;
    int k;
    logic [7:0] d;
    logic s;

    #3;
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_end", 32'(rx_end), 32'h0);
    chk("rst_full", 32'(rx_full), 32'h0);
    chk("rst_ovr", 32'(rx_overrun), 32'h0);
    chk("rst_ferr", 32'(rx_frame_err), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    tick(3);
    reset = 1'b1;
    tick(4);

    // Good frame with latency and busy-duration checks.
    e0 = end_cnt;
    f0 = err_cnt;
    b0 = busy_cnt;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_ends", 32'(end_cnt - e0), 32'd1);
    chk("a5_ferr", 32'(err_cnt - f0), 32'd0);
    chk("a5_busy", 32'(busy_cnt - b0), 32'd152);
    chk("a5_lat", 32'(end_cyc - rise_cyc), 32'd152);
    check_state("a5");

    // Short low glitch rejected after the half-bit check.
    e0 = end_cnt;
    f0 = err_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("gl_busy", 32'(busy_cnt - b0), 32'd8);
    chk("gl_ends", 32'(end_cnt - e0), 32'd0);
    chk("gl_ferr", 32'(err_cnt - f0), 32'd0);
    check_state("gl");

    // Framing error leaves unread buffer alone.
    ack_pulse();
    do_frame("f11", 8'h11, 1'b1);
    do_frame("ferr", 8'h3C, 1'b0);

    // Overrun, then ack clears both flags.
    do_frame("ovr", 8'h22, 1'b1);
    ack_pulse();
    check_state("ack");

    // Ack coinciding with the frame load edge.
    do_frame("c11", 8'h11, 1'b1);
    e0 = end_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        k = 0;
        while (!rx_busy && k < 100) begin
          @(negedge clk);
          k++;
        end
        chk("co_start", 32'(k < 100), 32'd1);
        repeat (151) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        chk("co_pulse", 32'(rx_end), 32'd1);
      end
    join
    model_frame(8'h22, 1'b1, 1'b1);
    chk("co_ends", 32'(end_cnt - e0), 32'd1);
    check_state("co");

    // Reset during data bit 4 aborts the frame.
    e0 = end_cnt;
    f0 = err_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(DIV + 4 * DIV + 8);
        #2 reset = 1'b0;
        #1;
        chk("mr_data", 32'(rx_data), 32'h0);
        chk("mr_full", 32'(rx_full), 32'h0);
        chk("mr_ovr", 32'(rx_overrun), 32'h0);
        chk("mr_busy", 32'(rx_busy), 32'h0);
      end
    join
    tick(2);
    reset = 1'b1;
    m_data = 8'h00;
    m_full = 1'b0;
    m_ovr = 1'b0;
    tick(4);
    chk("mr_ends", 32'(end_cnt - e0), 32'd0);
    chk("mr_ferr", 32'(err_cnt - f0), 32'd0);
    do_frame("r5a", 8'h5A, 1'b1);

    // Random frames, stop bits and acks.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      tick($urandom_range(0, 3));
      do_frame($sformatf("rnd%0d", i), d, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
